// File: rtl/mem_arbiter.sv
// Three-requester arbiter (ld, cpu, gpu) in front of a single-port byte
// memory with a registered 1-cycle read. ld has fixed priority; cpu/gpu
// share round-robin. A requester may lock the port for up to LOCK_MAX
// back-to-back grants. Writes into 0x000-0x1FF are granted but dropped
// and flagged on prot_err.
//
// Handshake: X_req is a request that must stay stable (with write, addr,
// wdata, lock) until X_gnt; X_gnt is combinational and means the access
// is issued to the memory in this same cycle. Dropping X_req before
// X_gnt cancels the request. For a granted read, X_rvalid is high for
// exactly one cycle on the next cycle, with rdata holding the data.
module mem_arbiter #(
  parameter int LOCK_MAX = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ld_req,
  input  logic        ld_write,
  input  logic [11:0] ld_addr,
  input  logic [7:0]  ld_wdata,
  input  logic        ld_lock,
  output logic        ld_gnt,
  output logic        ld_rvalid,
  input  logic        cpu_req,
  input  logic        cpu_write,
  input  logic [11:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  input  logic        cpu_lock,
  output logic        cpu_gnt,
  output logic        cpu_rvalid,
  input  logic        gpu_req,
  input  logic        gpu_write,
  input  logic [11:0] gpu_addr,
  input  logic [7:0]  gpu_wdata,
  input  logic        gpu_lock,
  output logic        gpu_gnt,
  output logic        gpu_rvalid,
  output logic [7:0]  rdata,
  output logic        mem_en,
  output logic        mem_write,
  output logic [11:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic        prot_err,
  output logic        dbg_locked
);

  localparam int CW = $clog2(LOCK_MAX + 1);

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;
  typedef enum logic [1:0] {OWN_LD = 2'd0, OWN_CPU = 2'd1, OWN_GPU = 2'd2} owner_t;

  state_t          state_q;
  owner_t          owner_q;
  logic [CW-1:0]   cnt_q;
  logic            last_gpu_q;   // 1: gpu won the last cpu/gpu tie-break
  logic [1:0]      run_q;        // grants open only after two sampled-high edges
  logic [2:0]      rv_q;         // {gpu, cpu, ld} read issued last cycle

  logic            owner_req;
  logic            hold;
  logic [2:0]      gnt_v;
  owner_t          gnt_id;
  logic            gnt_write;
  logic            gnt_lock;
  logic [11:0]     gnt_addr;
  logic [7:0]      gnt_wdata;
  logic            prot_hit;
  logic [CW-1:0]   cnt_next;

  // Owner's current request, used to keep or drop an active lock
  always_comb begin
    owner_req = 1'b0;
    case (owner_q)
      OWN_LD:  owner_req = ld_req;
      OWN_CPU: owner_req = cpu_req;
      OWN_GPU: owner_req = gpu_req;
      default: owner_req = 1'b0;
    endcase
  end

  assign hold = (state_q == LOCKED) && owner_req;

  // Grant selection: lock owner, else ld, else cpu/gpu round-robin
  always_comb begin
    gnt_v = 3'b000;
    if (run_q[1]) begin
      if (hold) begin
        case (owner_q)
          OWN_LD:  gnt_v = 3'b001;
          OWN_CPU: gnt_v = 3'b010;
          OWN_GPU: gnt_v = 3'b100;
          default: gnt_v = 3'b000;
        endcase
      end else if (ld_req) begin
        gnt_v = 3'b001;
      end else if (cpu_req && gpu_req) begin
        gnt_v = last_gpu_q ? 3'b010 : 3'b100;
      end else if (cpu_req) begin
        gnt_v = 3'b010;
      end else if (gpu_req) begin
        gnt_v = 3'b100;
      end
    end
  end

  // Route the winner's access fields to the memory side
  always_comb begin
    gnt_id    = OWN_LD;
    gnt_write = 1'b0;
    gnt_lock  = 1'b0;
    gnt_addr  = 12'h000;
    gnt_wdata = 8'h00;
    if (gnt_v[0]) begin
      gnt_id = OWN_LD;  gnt_write = ld_write;  gnt_lock = ld_lock;
      gnt_addr = ld_addr;  gnt_wdata = ld_wdata;
    end else if (gnt_v[1]) begin
      gnt_id = OWN_CPU; gnt_write = cpu_write; gnt_lock = cpu_lock;
      gnt_addr = cpu_addr; gnt_wdata = cpu_wdata;
    end else if (gnt_v[2]) begin
      gnt_id = OWN_GPU; gnt_write = gpu_write; gnt_lock = gpu_lock;
      gnt_addr = gpu_addr; gnt_wdata = gpu_wdata;
    end
  end

  // A protected write still takes its grant but never reaches the array
  assign prot_hit  = gnt_write && (gnt_addr[11:9] == 3'b000);
  assign cnt_next  = hold ? cnt_q + CW'(1) : CW'(1);

  assign ld_gnt    = gnt_v[0];
  assign cpu_gnt   = gnt_v[1];
  assign gpu_gnt   = gnt_v[2];
  assign mem_en    = |gnt_v;
  assign mem_write = gnt_write && !prot_hit;
  assign mem_addr  = gnt_addr;
  assign mem_wdata = gnt_wdata;
  assign prot_err  = prot_hit;

  assign ld_rvalid  = rv_q[0];
  assign cpu_rvalid = rv_q[1];
  assign gpu_rvalid = rv_q[2];
  assign rdata      = (|rv_q) ? mem_rdata : 8'h00;
  assign dbg_locked = (state_q == LOCKED);

  // Lock FSM, lock counter, round-robin history and read-return tags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      owner_q    <= OWN_LD;
      cnt_q      <= '0;
      last_gpu_q <= 1'b1;
      run_q      <= 2'b00;
      rv_q       <= 3'b000;
    end else begin
      run_q <= {run_q[0], 1'b1};
      rv_q  <= gnt_v & {3{~gnt_write}};
      if (gnt_v[1] || gnt_v[2])
        last_gpu_q <= gnt_v[2];
      if ((|gnt_v) && gnt_lock && (cnt_next < CW'(LOCK_MAX))) begin
        state_q <= LOCKED;
        owner_q <= gnt_id;
        cnt_q   <= cnt_next;
      end else if ((|gnt_v) || ((state_q == LOCKED) && !owner_req)) begin
        state_q <= IDLE;
        cnt_q   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: per-requester command queues drive the ports,
// a behavioural memory answers port A, and a scoreboard predicts every
// read return (cycle, requester, data) from an independent memory model.
module tb_mem_arbiter;

  logic        clk;
  logic        rst_n;
  logic [2:0]  req, wr, lk;
  logic [11:0] addr [3];
  logic [7:0]  wd [3];
  logic        ld_gnt, cpu_gnt, gpu_gnt;
  logic        ld_rvalid, cpu_rvalid, gpu_rvalid;
  logic [7:0]  rdata;
  logic        mem_en, mem_write;
  logic [11:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;
  logic        prot_err, dbg_locked;

  mem_arbiter #(.LOCK_MAX(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .ld_req(req[0]), .ld_write(wr[0]), .ld_addr(addr[0]), .ld_wdata(wd[0]),
    .ld_lock(lk[0]), .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid),
    .cpu_req(req[1]), .cpu_write(wr[1]), .cpu_addr(addr[1]), .cpu_wdata(wd[1]),
    .cpu_lock(lk[1]), .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid),
    .gpu_req(req[2]), .gpu_write(wr[2]), .gpu_addr(addr[2]), .gpu_wdata(wd[2]),
    .gpu_lock(lk[2]), .gpu_gnt(gpu_gnt), .gpu_rvalid(gpu_rvalid),
    .rdata(rdata), .mem_en(mem_en), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .prot_err(prot_err),
    .dbg_locked(dbg_locked)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- memory model (port A, registered read) ----------------
  logic [7:0] mem_arr [4096];
  logic [7:0] ref_mem [4096];
  initial begin
    mem_rdata = 8'h00;
    for (int i = 0; i < 4096; i++) begin
      mem_arr[i] = 8'(i * 7 + 3);
      ref_mem[i] = 8'(i * 7 + 3);
    end
  end
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_write) mem_arr[mem_addr] <= mem_wdata;
      else           mem_rdata <= mem_arr[mem_addr];
    end
  end

  // ---------------- checking ----------------
  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // ---------------- driver ----------------
  typedef struct packed {
    logic        g;   // idle one cycle before presenting this command
    logic        w;
    logic        l;
    logic [11:0] a;
    logic [7:0]  d;
  } cmd_t;

  cmd_t cq0[$], cq1[$], cq2[$];
  logic [2:0] gnt_s = 3'b000;

  function automatic cmd_t mk(input logic g, input logic w, input logic l,
                              input logic [11:0] a, input logic [7:0] d);
    cmd_t c;
    c.g = g; c.w = w; c.l = l; c.a = a; c.d = d;
    return c;
  endfunction

  task automatic apply(input int i, input logic have, input cmd_t c);
    req[i]  = have;
    wr[i]   = have ? c.w : 1'b0;
    lk[i]   = have ? c.l : 1'b0;
    addr[i] = have ? c.a : 12'h000;
    wd[i]   = have ? c.d : 8'h00;
  endtask

  initial begin
    cmd_t c;
    req = '0; wr = '0; lk = '0;
    for (int i = 0; i < 3; i++) begin addr[i] = '0; wd[i] = '0; end
    forever begin
      @(posedge clk); #1;
      if (gnt_s[0] && cq0.size() != 0) void'(cq0.pop_front());
      if (gnt_s[1] && cq1.size() != 0) void'(cq1.pop_front());
      if (gnt_s[2] && cq2.size() != 0) void'(cq2.pop_front());
      c = '0;
      if (cq0.size() != 0 && cq0[0].g) begin c = cq0[0]; c.g = 1'b0; cq0[0] = c; apply(0, 1'b0, c); end
      else begin if (cq0.size() != 0) c = cq0[0]; apply(0, cq0.size() != 0, c); end
      c = '0;
      if (cq1.size() != 0 && cq1[0].g) begin c = cq1[0]; c.g = 1'b0; cq1[0] = c; apply(1, 1'b0, c); end
      else begin if (cq1.size() != 0) c = cq1[0]; apply(1, cq1.size() != 0, c); end
      c = '0;
      if (cq2.size() != 0 && cq2[0].g) begin c = cq2[0]; c.g = 1'b0; cq2[0] = c; apply(2, 1'b0, c); end
      else begin if (cq2.size() != 0) c = cq2[0]; apply(2, cq2.size() != 0, c); end
    end
  end

  // ---------------- monitor + scoreboard ----------------
  logic [41:0] exp_q[$];   // {due cycle, requester, data}
  int          gnt_log[$];
  int          lk_log[$];
  int          prot_cnt = 0;
  logic [2:0]  g_m, rv_m;
  logic [41:0] e_m;
  int          id_m;
  int          rid_m;
  logic        pexp_m;

  always @(negedge clk) begin
    g_m   = {gpu_gnt, cpu_gnt, ld_gnt};
    rv_m  = {gpu_rvalid, cpu_rvalid, ld_rvalid};
    gnt_s = g_m;
    if (rst_n) begin
      if (prot_err) prot_cnt++;
      if (rv_m != 3'b000) begin
        chk("rv_onehot", $countones(rv_m), 1);
        rid_m = rv_m[0] ? 0 : (rv_m[1] ? 1 : 2);
        if (exp_q.size() == 0) chk("rv_unexpected", rv_m, 3'b000);
        else begin
          e_m = exp_q.pop_front();
          chk("read_ret", {32'(cyc), 2'(rid_m), rdata}, e_m);
        end
      end
      if (g_m != 3'b000) begin
        chk("gnt_onehot", $countones(g_m), 1);
        id_m = g_m[0] ? 0 : (g_m[1] ? 1 : 2);
        gnt_log.push_back(id_m);
        lk_log.push_back(int'(dbg_locked));
        pexp_m = wr[id_m] && (addr[id_m][11:9] == 3'b000);
        chk("prot_err", prot_err, pexp_m);
        chk("mem_en", mem_en, 1'b1);
        chk("mem_addr", mem_addr, addr[id_m]);
        chk("mem_write", mem_write, wr[id_m] && !pexp_m);
        if (wr[id_m]) begin
          chk("mem_wdata", mem_wdata, wd[id_m]);
          if (!pexp_m) ref_mem[addr[id_m]] = wd[id_m];
        end else begin
          exp_q.push_back({32'(cyc + 1), 2'(id_m), ref_mem[addr[id_m]]});
        end
      end else begin
        chk("idle_mem", {mem_en, mem_write, prot_err}, 3'b000);
      end
    end
  end

  // ---------------- helpers ----------------
  function automatic logic [63:0] pack_log(input int q[$]);
    logic [63:0] v;
    v = '0;
    foreach (q[i]) v = {v[61:0], 2'(q[i] + 1)};
    return v;
  endfunction

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((cq0.size() + cq1.size() + cq2.size() + exp_q.size()) != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) chk("drain_timeout", cq0.size() + cq1.size() + cq2.size() + exp_q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_zero(input string t);
    chk({t, "_gnt"}, {gpu_gnt, cpu_gnt, ld_gnt}, 3'b000);
    chk({t, "_rvalid"}, {gpu_rvalid, cpu_rvalid, ld_rvalid}, 3'b000);
    chk({t, "_ctl"}, {prot_err, mem_en, mem_write, dbg_locked}, 4'b0000);
    chk({t, "_addr"}, mem_addr, 12'h000);
    chk({t, "_wdata"}, mem_wdata, 8'h00);
    chk({t, "_rdata"}, rdata, 8'h00);
  endtask

  // ---------------- scenarios ----------------
  int exp_log[$];
  int p0;

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // priority: all three read together
    gnt_log.delete();
    cq0.push_back(mk(0, 0, 0, 12'h200, 8'h00));
    cq1.push_back(mk(0, 0, 0, 12'h300, 8'h00));
    cq2.push_back(mk(0, 0, 0, 12'h400, 8'h00));
    wait_idle(50);
    exp_log = '{0, 1, 2};
    chk("prio_seq", pack_log(gnt_log), pack_log(exp_log));

    // round-robin: cpu and gpu request continuously
    gnt_log.delete();
    for (int i = 0; i < 3; i++) begin
      cq1.push_back(mk(0, 0, 0, 12'h310 + 12'(i), 8'h00));
      cq2.push_back(mk(0, 0, 0, 12'h410 + 12'(i), 8'h00));
    end
    wait_idle(50);
    exp_log = '{1, 2, 1, 2, 1, 2};
    chk("rr_seq", pack_log(gnt_log), pack_log(exp_log));

    // lock: gpu locked burst of 20 reads, cpu waiting throughout
    gnt_log.delete();
    for (int i = 0; i < 20; i++) cq2.push_back(mk(0, 0, 1, 12'h500 + 12'(i), 8'h00));
    @(negedge clk);
    for (int i = 0; i < 3; i++) cq1.push_back(mk(0, 0, 0, 12'h320 + 12'(i), 8'h00));
    wait_idle(100);
    exp_log.delete();
    for (int i = 0; i < 16; i++) exp_log.push_back(2);
    exp_log.push_back(1);
    for (int i = 0; i < 4; i++) exp_log.push_back(2);
    exp_log.push_back(1);
    exp_log.push_back(1);
    chk("lock_len", gnt_log.size(), exp_log.size());
    chk("lock_seq", pack_log(gnt_log), pack_log(exp_log));
    chk("lock_idle_end", dbg_locked, 1'b0);

    // early release: gpu drops req mid-burst while cpu waits
    gnt_log.delete();
    lk_log.delete();
    for (int i = 0; i < 8; i++) cq2.push_back(mk(i == 3, 0, 1, 12'h600 + 12'(i), 8'h00));
    @(negedge clk);
    for (int i = 0; i < 2; i++) cq1.push_back(mk(0, 0, 0, 12'h330 + 12'(i), 8'h00));
    wait_idle(60);
    exp_log = '{2, 2, 2, 1, 2, 2, 2, 2, 2, 1};
    chk("early_seq", pack_log(gnt_log), pack_log(exp_log));
    exp_log = '{0, 1, 1, 1, 0, 1, 1, 1, 1, 1};
    chk("early_lock_state", pack_log(lk_log), pack_log(exp_log));
    chk("early_idle_end", dbg_locked, 1'b0);

    // write protect: 0x1FF dropped and flagged, 0x200 written
    p0 = prot_cnt;
    cq1.push_back(mk(0, 1, 0, 12'h1FF, 8'hAA));
    cq1.push_back(mk(0, 1, 0, 12'h200, 8'h55));
    cq1.push_back(mk(0, 0, 0, 12'h1FF, 8'h00));
    cq1.push_back(mk(0, 0, 0, 12'h200, 8'h00));
    wait_idle(40);
    chk("prot_pulses", prot_cnt - p0, 1);
    chk("prot_model_1ff", ref_mem[12'h1FF], 8'(12'h1FF * 7 + 3));
    chk("wr_model_200", ref_mem[12'h200], 8'h55);

    // random mixed traffic, no locks
    for (int i = 0; i < 30; i++) begin
      cmd_t c;
      c = mk(0, 1'($urandom_range(0, 1)), 0, 12'($urandom_range(0, 4095)), 8'($urandom_range(0, 255)));
      case ($urandom_range(0, 2))
        0: cq0.push_back(c);
        1: cq1.push_back(c);
        default: cq2.push_back(c);
      endcase
    end
    wait_idle(200);

    // reset in the cycle after a cpu read grant
    cq1.push_back(mk(0, 0, 0, 12'h700, 8'h00));
    p0 = 0;
    while (!cpu_gnt && p0 < 20) begin @(negedge clk); p0++; end
    chk("mid_rst_grant_seen", cpu_gnt, 1'b1);
    cq1.push_back(mk(0, 0, 0, 12'h701, 8'h00));
    @(posedge clk); #2;
    rst_n = 1'b0;
    @(negedge clk);
    exp_q.delete();
    check_zero("mid_rst");
    @(negedge clk);
    check_zero("mid_rst_hold");
    rst_n = 1'b1;
    @(negedge clk);
    chk("first_cycle_gnt", {gpu_gnt, cpu_gnt, ld_gnt}, 3'b000);
    chk("first_cycle_rvalid", cpu_rvalid, 1'b0);
    wait_idle(40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter LOCK_MAX, default 16, the maximum consecutive grants one requester may hold under lock.
REQ-002 SHALL have port clk, input, 1 bit, the single clock, which also drives the CPU memory port A clock.
REQ-003 SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-004 SHALL have, for each requester X in {ld, cpu, gpu}, these ports:
- X_req, input, 1: access request.
- X_write, input, 1: write when 1, read when 0.
- X_addr, input, 12: byte address.
- X_wdata, input, 8: write data.
- X_lock, input, 1: hold ownership for back-to-back accesses.
- X_gnt, output, 1: access accepted this cycle.
- X_rvalid, output, 1: read data valid.
REQ-005 SHALL have port rdata, output, 8, shared read data, meaningful only when some X_rvalid is 1.
REQ-006 SHALL have memory-side ports mem_en, mem_write, mem_addr[11:0] and mem_wdata[7:0] as outputs, and mem_rdata[7:0] as input (port A, registered read, 1-cycle latency).
REQ-007 SHALL have port prot_err, output, 1, a pulse flagging a granted write into 0x000-0x1FF.

Function
REQ-008 SHALL issue at most one grant per cycle, combinationally on X_req, with mem_en=X_gnt and mem_write/addr/wdata taken from the granted requester in the same cycle.
REQ-009 SHALL keep a requester's req, write, addr and wdata stable until its X_gnt; releasing X_req before grant is legal and cancels the request.
REQ-010 SHALL give ld fixed highest priority over cpu and gpu when no lock is held.
REQ-011 SHALL arbitrate cpu and gpu round-robin via a 1-bit last-winner register: on a tie, grant the one that did not win last; the register updates only on cpu/gpu grants; reset value favours cpu.
REQ-012 SHALL use FSM states IDLE and LOCKED(owner):
- IDLE to LOCKED: on a grant with X_lock=1.
- LOCKED to IDLE: on a cycle with owner X_lock=0, or when the lock count reaches LOCK_MAX.
REQ-013 SHALL, in LOCKED, grant only the owner (including ld if ld owns the lock), stalling every other requester.
REQ-014 SHALL increment a lock count per owner grant; at count==LOCK_MAX, force IDLE, then apply normal priority the next cycle; count clears on entry to IDLE.
REQ-015 SHALL, after a read grant, assert X_rvalid for exactly one cycle on the following cycle, with rdata=mem_rdata; the owner tag is registered so rvalid routing is unaffected by the next grant.
REQ-016 SHALL assert no rvalid for a write grant.
REQ-017 SHALL pipeline back-to-back reads: a grant in cycle N+1 is allowed while the rvalid of cycle N's read is presented.
REQ-018 SHALL pulse prot_err in the grant cycle for a granted write with addr[11:9]==0; the grant is still given, the memory drops the write, and no retry occurs.
REQ-019 SHALL drop the lock immediately, with no further owner grant that cycle, if the owner deasserts X_req while LOCKED.
REQ-020 SHALL output mem_en=0 and mem_write=0 when nothing is granted.

Reset
REQ-021 SHALL, on rst_n=0, immediately force all X_gnt, X_rvalid, prot_err, mem_en and mem_write to 0, mem_addr, mem_wdata and rdata to 0, FSM to IDLE, lock count to 0 and last-winner to gpu (cpu favoured next).
REQ-022 SHALL discard any read in flight at reset: no rvalid appears after rst_n deasserts.
REQ-023 SHALL grant nothing in the first cycle that rst_n is sampled high.

Verification
REQ-024 SHALL be verified for priority:
- Stimulus: ld, cpu and gpu all read in the same cycle, at 0x200, 0x300 and 0x400.
- Response: ld_gnt first, then cpu, then gpu on consecutive cycles; each rvalid one cycle after its grant, with matching mem data.
REQ-025 SHALL be verified for round-robin:
- Stimulus: cpu and gpu request continuously for 6 cycles.
- Response: grants alternate cpu, gpu, cpu, gpu, cpu, gpu.
REQ-026 SHALL be verified for lock:
- Stimulus: gpu_lock=1 with 20 reads from 0x500 upward; cpu requests throughout.
- Response: 16 consecutive gpu grants, then one cpu grant, then gpu resumes.
REQ-027 SHALL be verified for write protect:
- Stimulus: cpu writes 0xAA to 0x1FF, then 0x55 to 0x200.
- Response: prot_err=1 only with the first grant; reads return the original 0x1FF content and 0x55.
REQ-028 SHALL be verified for reset mid-read:
- Stimulus: assert rst_n=0 the cycle after a cpu read grant.
- Response: cpu_rvalid never asserts; all outputs are 0 during reset.
REQ-029 SHALL be verified for early release:
- Stimulus: gpu locked, gpu_req drops mid-burst while cpu requests.
- Response: cpu granted on the cycle gpu_req is low; FSM returns to IDLE.
